// File: rtl/home_uart_pkg.sv
// Shared definitions for the home-automation UART transmitter and receiver:
// frame state encoding, data width and serial line levels.
package home_uart_pkg;

  localparam int DATA_BITS = 8;

  // Line levels of the asynchronous frame.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage : home_uart_pkg

// File: rtl/home_cmd_uart_tx_if.sv
// Valid/ready byte handshake between the home-automation controller
// (master) and the serial transmitter (slave).
interface home_cmd_uart_tx_if;
  import home_uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface : home_cmd_uart_tx_if

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_done = (count == LAST);

  // Free-running period counter, held at zero while cleared, wrapping explicitly
  // so non-power-of-two periods work.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop sees pre-edge values.
    if (rst || clear) begin
      count <= '0;
    end else if (bit_done) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule : uart_bit_timer

// File: rtl/home_cmd_uart_tx.sv
// Serial transmitter for appliance command bytes: start bit, 8 data bits
// LSB first, optional even parity, one stop bit. All outputs except
// tx_ready are registered.
module home_cmd_uart_tx
  import home_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  home_cmd_uart_tx_if.slave        bus,
  output logic                     tx_line,
  output logic                     busy
);

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [IDX_W-1:0]     bit_idx;
  logic                 bit_done;
  logic                 ready;
  logic                 accept;

  // NOTE: tx_ready includes rst combinationally so a byte offered during the
  // reset cycle is never acknowledged to the producer.
  assign ready        = (state == IDLE) && !rst;
  assign bus.tx_ready = ready;
  assign accept       = bus.tx_valid && ready;

  // The timer sits at zero while idle, so the start bit gets a full period.
  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .bit_done (bit_done)
  );

  // Frame sequencer: owns state, shift register, parity, bit index and the
  // registered line/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_line  <= LINE_IDLE;
      busy     <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_q  <= bus.tx_data;
            parity_q <= ^bus.tx_data;
            bit_idx  <= '0;
            state    <= START;
            tx_line  <= LINE_START;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx_line <= shift_q[0];
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state   <= PARITY;
                tx_line <= parity_q;
              end else begin
                state   <= STOP;
                tx_line <= LINE_STOP;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shift_q <= shift_q >> 1;
              tx_line <= shift_q[1];
            end
          end
        end

        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            tx_line <= LINE_STOP;
          end
        end

        STOP: begin
          if (bit_done) begin
            state   <= IDLE;
            tx_line <= LINE_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          tx_line <= LINE_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : home_cmd_uart_tx

// File: tb/tb_home_cmd_uart_tx.sv
// Directed bench for home_cmd_uart_tx: one instance with parity, one without,
// both at 4 clocks per bit. Inputs driven and outputs sampled on the falling edge.
module tb_home_cmd_uart_tx;
  import home_uart_pkg::*;

  localparam int C = 4;

  logic clk = 1'b0;
  logic rst;
  logic line_p, busy_p, line_n, busy_n;
  int   n_vec = 0;
  int   n_bad = 0;

  home_cmd_uart_tx_if bus_p ();
  home_cmd_uart_tx_if bus_n ();

  home_cmd_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p), .tx_line(line_p), .busy(busy_p)
  );

  home_cmd_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n), .tx_line(line_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_line(input bit np);
    return np ? line_n : line_p;
  endfunction

  function automatic logic get_busy(input bit np);
    return np ? busy_n : busy_p;
  endfunction

  function automatic logic get_ready(input bit np);
    return np ? bus_n.tx_ready : bus_p.tx_ready;
  endfunction

  task automatic set_valid(input bit np, input logic v);
    if (np) bus_n.tx_valid = v;
    else    bus_p.tx_valid = v;
  endtask

  task automatic set_data(input bit np, input logic [7:0] d);
    if (np) bus_n.tx_data = d;
    else    bus_p.tx_data = d;
  endtask

  task automatic check_idle(input bit np, input string tag);
    check({tag, " idle line"},  get_line(np),  1'b1);
    check({tag, " idle busy"},  get_busy(np),  1'b0);
    check({tag, " idle ready"}, get_ready(np), 1'b1);
  endtask

  // Offer a byte at the current falling edge; return in the first frame cycle.
  task automatic send_start(input bit np, input logic [7:0] d, input string tag);
    set_valid(np, 1'b1);
    set_data(np, d);
    #1;
    check({tag, " ready at offer"}, get_ready(np), 1'b1);
    @(negedge clk);
  endtask

  // Check every cycle of a frame against hand-supplied data and parity.
  task automatic frame_bits(input bit np, input logic [7:0] d, input logic par,
                            input bit drop_valid, input bit scramble, input string tag);
    int   nf;
    logic exp;
    nf = np ? 10 : 11;
    if (drop_valid) set_valid(np, 1'b0);
    for (int b = 0; b < nf; b++) begin
      if (b == 0)                exp = LINE_START;
      else if (b <= 8)           exp = d[b-1];
      else if (b == 9 && !np)    exp = par;
      else                       exp = LINE_STOP;
      for (int k = 0; k < C; k++) begin
        check($sformatf("%s line bit%0d cyc%0d", tag, b, k), get_line(np), exp);
        check($sformatf("%s busy bit%0d cyc%0d", tag, b, k), get_busy(np), 1'b1);
        if (b == 0 && k == 0) check({tag, " ready in frame"}, get_ready(np), 1'b0);
        if (scramble) set_data(np, 8'($urandom));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus_p.tx_valid = 1'b0; bus_p.tx_data = 8'h00;
    bus_n.tx_valid = 1'b0; bus_n.tx_data = 8'h00;

    // Reset held 3 cycles, with a byte offered throughout: reset must win.
    @(negedge clk);
    bus_p.tx_valid = 1'b1; bus_p.tx_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst line_p %0d", i), line_p, 1'b1);
      check($sformatf("rst busy_p %0d", i), busy_p, 1'b0);
      check($sformatf("rst ready_p %0d", i), bus_p.tx_ready, 1'b0);
      check($sformatf("rst line_n %0d", i), line_n, 1'b1);
      check($sformatf("rst ready_n %0d", i), bus_n.tx_ready, 1'b0);
    end
    rst = 1'b0;
    bus_p.tx_valid = 1'b0;
    #1;
    check("post-rst ready_p", bus_p.tx_ready, 1'b1);
    check("post-rst ready_n", bus_n.tx_ready, 1'b1);
    @(negedge clk);
    check_idle(1'b0, "no accept in rst");

    // 0xA5 with parity: even weight, parity bit 0; 44 busy cycles.
    send_start(1'b0, 8'hA5, "a5");
    frame_bits(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, "a5");
    check_idle(1'b0, "a5 cyc45");
    @(negedge clk);

    // 0x07: odd weight, parity bit 1.
    send_start(1'b0, 8'h07, "07");
    frame_bits(1'b0, 8'h07, 1'b1, 1'b1, 1'b0, "07");
    check_idle(1'b0, "07 end");
    @(negedge clk);

    // 0x3C without parity: 40-cycle frame, stop right after data bit 7.
    send_start(1'b1, 8'h3C, "3c");
    frame_bits(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, "3c");
    check_idle(1'b1, "3c end");
    @(negedge clk);

    // Back-to-back 0x55 then 0xAA, valid held high, data scrambled mid-frame.
    send_start(1'b0, 8'h55, "55");
    frame_bits(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, "55");
    check_idle(1'b0, "b2b gap");
    send_start(1'b0, 8'hAA, "aa");
    frame_bits(1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, "aa");
    check_idle(1'b0, "aa end");
    @(negedge clk);

    // Reset during data bit 3 of 0x00, then a clean 0x81 frame.
    send_start(1'b0, 8'h00, "abort");
    set_valid(1'b0, 1'b0);
    repeat (17) @(negedge clk);
    check("abort line in bit3", line_p, 1'b0);
    check("abort busy in bit3", busy_p, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort line after rst", line_p, 1'b1);
    check("abort busy after rst", busy_p, 1'b0);
    check("abort ready in rst", bus_p.tx_ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check_idle(1'b0, $sformatf("abort quiet %0d", i));
      @(negedge clk);
    end
    send_start(1'b0, 8'h81, "81");
    frame_bits(1'b0, 8'h81, 1'b0, 1'b1, 1'b0, "81");
    check_idle(1'b0, "81 end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_home_cmd_uart_tx

// File: doc/home_cmd_uart_tx.md
# home_cmd_uart_tx

Serial transmitter that turns 8-bit appliance command bytes into asynchronous frames on a single line, built from registered (flip-flop) state only. The home-automation controller hands it bytes through a valid/ready handshake, and the block drives the output line toward the relay/appliance nodes. It is the sending side of the node's byte receiver: it converts parallel data to serial, where the receiver samples serial data back to parallel.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- tx_data  input  8  command byte. Sampled only on handshake.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block accepts a byte this cycle.
- tx_line  output  1  serial output. Idle level is 1.
- busy  output  1  a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, busy=0, tx_line=1.
  - On tx_valid & tx_ready at an edge: latch tx_data into the shift register, compute the parity bit (XOR of the 8 bits), clear the bit timer and bit index, then go to START.
- START: tx_line=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Sends 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - The index runs 0..7. After index 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_line = latched parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: tx_line=1 for CLKS_PER_BIT cycles, then IDLE.
- busy=1 in every state except IDLE. tx_ready = (state==IDLE) & ~rst.
- tx_data and tx_valid are ignored while busy. Changes to tx_data mid-frame have no effect.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - bit_done pulses when the count reaches CLKS_PER_BIT-1, and the timer then wraps to 0.
  - The bit index is 3 bits and advances only on bit_done in DATA.
- Reset values: state=IDLE, tx_line=1, busy=0, timer=0, index=0, shift register=0. tx_ready=0 while rst=1.
- Reset mid-frame aborts the frame. At the reset edge tx_line returns to 1 and the partial byte is discarded; no stop bit is completed.

## Timing
- tx_line, busy and state are registered outputs. tx_ready is combinational from state and rst.
- Handshake: accept at edge N. tx_line=0 and busy=1 from cycle N+1.
- Frame length is F×CLKS_PER_BIT cycles, where F = 11 with parity and 10 without. busy is high for exactly that many cycles.
- The cycle after the last STOP cycle is IDLE with tx_ready=1.
- Back-to-back frames with tx_valid held high:
  - The next start bit begins 1 cycle after IDLE is entered.
  - So there are exactly CLKS_PER_BIT+1 line-high cycles between data frames (stop bit plus one idle cycle).
- rst and tx_valid asserted in the same cycle: reset wins, and no byte is accepted.

## Structure
- Package home_uart_pkg holds:
  - the state enum (tx_state_t: IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - the idle/start/stop line-level constants.
- The receiver imports the same package.
- One natural sub-module: uart_bit_timer. It is the CLKS_PER_BIT counter with clear input and bit_done output, and it is reusable by the receiver.
- The top level holds the FSM, shift register, parity register and bit index.

## Test plan
- Reset defaults: CLKS_PER_BIT=4, PARITY_EN=1. Hold rst 3 cycles → tx_line=1, busy=0, tx_ready=0 during reset, then tx_ready=1 on the first cycle after reset.
- Single frame with parity: send 0xA5 → tx_line per 4-cycle bit is 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1. busy is high exactly 44 cycles, and tx_ready returns 1 on cycle 45.
- Odd-weight byte: send 0x07 → data bits 1,1,1,0,0,0,0,0, then parity bit 1.
- No parity: PARITY_EN=0, send 0x3C → 10-bit frame of 40 cycles, with the stop bit directly after data bit 7 (value 0).
- Back-to-back and busy-ignore:
  - Hold tx_valid=1 with 0x55 then 0xAA → both frames are correct, with 5 high cycles between the last data/parity bit and the next start bit.
  - Toggling tx_data mid-frame does not alter the frame in flight.
- Reset mid-frame: assert rst during DATA bit 3 → tx_line=1 and busy=0 at the next edge, and no residual bits afterward. A following send of 0x81 produces a clean frame.
